gmii_mac_tx: RTL

GMII_MAC_TX -- requirements
Module: gmii_mac_tx

---
 rtl/eth_pkg.sv | 32 +++
 rtl/gmii_mac_tx_if.sv | 26 ++
 rtl/eth_crc32_d8.sv | 24 ++
 rtl/gmii_mac_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet TX constants, FSM states and CRC polynomial helpers
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
   localparam logic [7:0]  ETH_SFD       = 8'hD5;
   localparam int          ETH_MIN_FRAME = 60;
   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_PAYLOAD,
      ST_PAD,
      ST_FCS,
      ST_WAIT_END,
      ST_IFG
   } tx_state_e;

   function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // Ethernet shifts bits LSB first, so the register works with the mirrored polynomial
   localparam logic [31:0] CRC32_POLY_REFL = bit_reverse32(CRC32_POLY);

endpackage

// File: rtl/gmii_mac_tx_if.sv
// rtl/gmii_mac_tx_if.sv - byte stream feeding the GMII transmitter
interface gmii_mac_tx_if;

   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      output tuser,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      input  tuser,
      output tready
   );

endinterface

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - combinational CRC-32 next state for one byte, LSB first
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] crc_work;

   always_comb begin
      crc_work = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_work[0] ^ data[i]) begin
            crc_work = (crc_work >> 1) ^ CRC32_POLY_REFL;
         end else begin
            crc_work = crc_work >> 1;
         end
      end
      crc_out = crc_work;
   end

endmodule

// File: rtl/gmii_mac_tx.sv
// rtl/gmii_mac_tx.sv - GMII transmit MAC: preamble, payload, optional pad, FCS, inter-frame gap
// Minimum-frame padding is built only when GMII_MAC_TX_PAD_EN is defined.
module gmii_mac_tx
   import eth_pkg::*;
#(
   parameter int unsigned IFG = 12
)(
   input  logic                clk,
   input  logic                rst,
   gmii_mac_tx_if.slave        s_axis,
   output logic [7:0]          gmii_txd,
   output logic                gmii_tx_en,
   output logic                gmii_tx_er,
   output logic                start_packet,
   output logic                error_underflow
);

   localparam logic [5:0] MIN_FRAME = 6'(ETH_MIN_FRAME);
   localparam logic [7:0] IFG_LAST  = 8'(IFG - 1);

   tx_state_e   state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [7:0]  ifg_cnt_q, ifg_cnt_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  txd_q, txd_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;
   logic        start_q, start_d;
   logic        underflow_q, underflow_d;

   logic [7:0]  crc_byte;
   logic [31:0] crc_next;
   logic [31:0] fcs;
   logic [5:0]  cnt_inc;
   logic        pad_needed;

   // Pad bytes enter the CRC as zeros, payload bytes straight from the stream
   assign crc_byte = (state_q == ST_PAYLOAD) ? s_axis.tdata : 8'h00;

   eth_crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (crc_byte),
      .crc_out (crc_next)
   );

   assign fcs     = ~crc_q;
   assign cnt_inc = (cnt_q == MIN_FRAME) ? MIN_FRAME : cnt_q + 6'd1;

`ifdef GMII_MAC_TX_PAD_EN
   assign pad_needed = (cnt_inc < MIN_FRAME);
`else
   assign pad_needed = 1'b0;
`endif

   assign s_axis.tready = (state_q == ST_PAYLOAD) || (state_q == ST_WAIT_END);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      ifg_cnt_d   = ifg_cnt_q;
      crc_d       = crc_q;
      txd_d       = 8'h00;
      tx_en_d     = 1'b0;
      tx_er_d     = 1'b0;
      start_d     = 1'b0;
      underflow_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s_axis.tvalid) begin
               state_d = ST_PREAMBLE;
               idx_d   = 3'd1;
               cnt_d   = 6'd0;
               crc_d   = CRC32_INIT;
               txd_d   = ETH_PREAMBLE;
               tx_en_d = 1'b1;
               start_d = 1'b1;
            end
         end

         // idx counts preamble bytes already on the wire; the eighth is the SFD
         ST_PREAMBLE: begin
            tx_en_d = 1'b1;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               txd_d   = ETH_SFD;
               state_d = ST_PAYLOAD;
            end else begin
               txd_d = ETH_PREAMBLE;
            end
         end

         ST_PAYLOAD: begin
            tx_en_d = 1'b1;
            if (s_axis.tvalid) begin
               txd_d   = s_axis.tdata;
               tx_er_d = s_axis.tlast & s_axis.tuser;
               crc_d   = crc_next;
               cnt_d   = cnt_inc;
               if (s_axis.tlast) begin
                  idx_d   = 3'd0;
                  state_d = pad_needed ? ST_PAD : ST_FCS;
               end
            end else begin
               tx_er_d     = 1'b1;
               underflow_d = 1'b1;
               state_d     = ST_WAIT_END;
            end
         end

         ST_PAD: begin
            tx_en_d = 1'b1;
            crc_d   = crc_next;
            cnt_d   = cnt_inc;
            if (cnt_inc == MIN_FRAME) begin
               idx_d   = 3'd0;
               state_d = ST_FCS;
            end
         end

         ST_FCS: begin
            tx_en_d = 1'b1;
            txd_d   = fcs[{idx_q[1:0], 3'b000} +: 8];
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd3) begin
               ifg_cnt_d = 8'd0;
               state_d   = ST_IFG;
            end
         end

         // Truncated frame: swallow the rest of it so the next frame starts clean
         ST_WAIT_END: begin
            if (s_axis.tvalid && s_axis.tlast) begin
               ifg_cnt_d = 8'd0;
               state_d   = ST_IFG;
            end
         end

         ST_IFG: begin
            ifg_cnt_d = ifg_cnt_q + 8'd1;
            if (ifg_cnt_q == IFG_LAST) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 3'd0;
         cnt_q       <= 6'd0;
         ifg_cnt_q   <= 8'd0;
         crc_q       <= CRC32_INIT;
         txd_q       <= 8'h00;
         tx_en_q     <= 1'b0;
         tx_er_q     <= 1'b0;
         start_q     <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         ifg_cnt_q   <= ifg_cnt_d;
         crc_q       <= crc_d;
         txd_q       <= txd_d;
         tx_en_q     <= tx_en_d;
         tx_er_q     <= tx_er_d;
         start_q     <= start_d;
         underflow_q <= underflow_d;
      end
   end

   assign gmii_txd        = txd_q;
   assign gmii_tx_en      = tx_en_q;
   assign gmii_tx_er      = tx_er_q;
   assign start_packet    = start_q;
   assign error_underflow = underflow_q;

endmodule
